// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size codes, FSM states, request check.
// LSU_SUBWORD_EN enables byte/halfword accesses; without it only words are legal.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD_EN = 1'b1;
`else
    localparam bit SUBWORD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } lsu_state_t;

    // True when a request must be rejected without touching memory.
    function automatic logic req_bad(
        input logic [1:0]  sz,
        input logic [31:0] a,
        input int          mem_bytes
    );
        logic [32:0] last;
        logic        bad_sz;
        logic        misal;
        // Highest byte of the aligned word that would be accessed.
        last   = {1'b0, a[31:2], 2'b11};
        bad_sz = (sz == SZ_BAD) || (!SUBWORD_EN && sz != SZ_WORD);
        misal  = (sz == SZ_HALF && a[0]) ||
                 (sz == SZ_WORD && a[1:0] != 2'b00);
        return bad_sz || misal || (last >= 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data memory port: word address, write data/strobe, read strobe, read data.
// master = load/store unit, slave = memory (readData valid cycle after read).
interface load_store_unit_if;

    logic [31:0] address;
    logic [31:0] writeData;
    logic        memoryWrite;
    logic        memoryRead;
    logic [31:0] readData;

    modport master (
        output address,
        output writeData,
        output memoryWrite,
        output memoryRead,
        input  readData
    );

    modport slave (
        input  address,
        input  writeData,
        input  memoryWrite,
        input  memoryRead,
        output readData
    );

endinterface

// File: rtl/lsu_lane_format.sv
// Big-endian lane logic: load extract/extend and store lane merge.
// Ports: size, offset, sign_ext, rdata, wdata in; load_val, merged out.
`ifdef LSU_SUBWORD_EN
module lsu_lane_format
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  bval;
    logic [15:0] hval;

    always_comb begin
        // Byte k lives at bits [31-8k -: 8], i.e. shifted by 8*(3-k).
        bsh      = {~offset, 3'b000};
        hsh      = {~offset[1], 4'b0000};
        bval     = 8'(rdata >> bsh);
        hval     = 16'(rdata >> hsh);
        load_val = rdata;
        merged   = wdata;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{sign_ext & bval[7]}}, bval};
                merged   = (rdata & ~(32'h0000_00FF << bsh)) |
                           ({24'b0, wdata[7:0]} << bsh);
            end
            SZ_HALF: begin
                load_val = {{16{sign_ext & hval[15]}}, hval};
                merged   = (rdata & ~(32'h0000_FFFF << hsh)) |
                           ({16'b0, wdata[15:0]} << hsh);
            end
            default: ;
        endcase
    end

endmodule
`endif

// File: rtl/load_store_unit.sv
// Load/store unit: one CPU request at a time against a word memory port.
// Ports: clk, reset, start/opWrite/size/signedLoad/cpuAddress/cpuWriteData
// in; busy/done/error/loadData out; mem = memory master port.
// LSU_SUBWORD_EN adds byte/halfword loads and read-modify-write stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        opWrite,
    input  logic [1:0]  size,
    input  logic        signedLoad,
    input  logic [31:0] cpuAddress,
    input  logic [31:0] cpuWriteData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] loadData,
    load_store_unit_if.master mem
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        wr_q;
    logic        req_write;
    logic [31:0] fmt_load;
    logic [31:0] fmt_merge;
    logic        bad;
    logic        direct_wr;

    assign bad       = req_bad(size, cpuAddress, MEM_BYTES);
    assign direct_wr = opWrite && (size == SZ_WORD);

`ifdef LSU_SUBWORD_EN
    logic [1:0]  req_size;
    logic [1:0]  req_off;
    logic        req_signed;
    logic [31:0] req_data;

    lsu_lane_format u_fmt (
        .size     (req_size),
        .offset   (req_off),
        .sign_ext (req_signed),
        .rdata    (mem.readData),
        .wdata    (req_data),
        .load_val (fmt_load),
        .merged   (fmt_merge)
    );
`else
    logic unused_sigs;
    assign unused_sigs = signedLoad;
    assign fmt_load    = mem.readData;
    assign fmt_merge   = wdata_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            loadData  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            req_write <= 1'b0;
`ifdef LSU_SUBWORD_EN
            req_size   <= SZ_WORD;
            req_off    <= 2'b00;
            req_signed <= 1'b0;
            req_data   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    req_write <= opWrite;
`ifdef LSU_SUBWORD_EN
                    req_size   <= size;
                    req_off    <= cpuAddress[1:0];
                    req_signed <= signedLoad;
                    req_data   <= cpuWriteData;
`endif
                    if (bad) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        busy   <= 1'b1;
                        addr_q <= {cpuAddress[31:2], 2'b00};
                        if (direct_wr) begin
                            state   <= S_WR;
                            wr_q    <= 1'b1;
                            wdata_q <= cpuWriteData;
                        end else begin
                            // Loads and sub-word stores read first.
                            state <= S_RD;
                            rd_q  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    rd_q  <= 1'b0;
                    state <= S_CAP;
                end
                S_CAP: if (req_write) begin
                    wdata_q <= fmt_merge;
                    wr_q    <= 1'b1;
                    state   <= S_WR;
                end else begin
                    loadData <= fmt_load;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_DONE;
                end
                S_WR: begin
                    wr_q  <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem.address     = addr_q;
    assign mem.writeData   = wdata_q;
    assign mem.memoryRead  = rd_q;
    assign mem.memoryWrite = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plus random requests checked
// against a byte-array memory model with big-endian access rules.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        opWrite;
    logic [1:0]  size;
    logic        signedLoad;
    logic [31:0] cpuAddress;
    logic [31:0] cpuWriteData;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] loadData;

    logic        preload;
    logic [31:0] mem_w [16];
    logic [31:0] rdata;
    logic [7:0]  refb [64];
    logic [31:0] exp_ld;
    int          total = 0;
    int          bad = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;

    load_store_unit_if m ();
    assign m.readData = rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .opWrite      (opWrite),
        .size         (size),
        .signedLoad   (signedLoad),
        .cpuAddress   (cpuAddress),
        .cpuWriteData (cpuWriteData),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .loadData     (loadData),
        .mem          (m)
    );

    function automatic logic [31:0] seed(int i);
        return (32'(i) * 32'h0103_0507) ^ 32'hA5C3_1E77;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem_w[i] <= seed(i);
        end else if (m.memoryWrite) begin
            mem_w[m.address[5:2]] <= m.writeData;
        end
        if (m.memoryRead) rdata <= mem_w[m.address[5:2]];
    end

    always @(posedge clk) begin
        if (m.memoryRead) rd_cnt <= rd_cnt + 1;
        if (m.memoryWrite) wr_cnt <= wr_cnt + 1;
        if (m.memoryRead && m.memoryWrite) both_cnt <= both_cnt + 1;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'd3;
        return {refb[b], refb[b + 1], refb[b + 2], refb[b + 3]};
    endfunction

    task automatic run_req(bit wr, logic [1:0] sz, bit sg,
                           logic [31:0] a, logic [31:0] d, string tag);
        int          n;
        int          lat;
        int          rd0;
        int          wr0;
        int          e_lat;
        int          e_rd;
        int          e_wr;
        bit          e_err;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e_err = (sz == 2'd3) || (!SUB && sz != 2'd2) ||
                (a % n != 0) || ((a - a % 4) + 3 >= 64);
        e_rd = 0;
        e_wr = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (wr) begin
            e_rd  = (n < 4) ? 1 : 0;
            e_wr  = 1;
            e_lat = (n < 4) ? 4 : 2;
            for (int i = 0; i < n; i++)
                refb[a + i] = 8'(d >> (8 * (n - 1 - i)));
        end else begin
            e_rd  = 1;
            e_lat = 3;
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(refb[a + i]);
            if (sg && n < 4 && v[8 * n - 1])
                v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp_ld = v;
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        opWrite      = wr;
        size         = sz;
        signedLoad   = sg;
        cpuAddress   = a;
        cpuWriteData = d;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        opWrite      = 1'($urandom);
        size         = 2'($urandom);
        cpuAddress   = $urandom;
        cpuWriteData = $urandom;
        lat = 1;
        check({tag, ".busy"}, 32'(busy), 32'(!e_err));
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(e_lat));
        check({tag, ".error"}, 32'(error), 32'(e_err));
        check({tag, ".loadData"}, loadData, exp_ld);
        check({tag, ".reads"}, 32'(rd_cnt - rd0), 32'(e_rd));
        check({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(e_wr));
        if (wr && !e_err)
            check({tag, ".memword"}, mem_w[a[5:2]], ref_word(a));
        @(negedge clk);
        check({tag, ".donepulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [7:0] dmask;
        int         rd0;
        reset        = 1'b1;
        preload      = 1'b1;
        start        = 1'b0;
        opWrite      = 1'b0;
        size         = 2'd2;
        signedLoad   = 1'b0;
        cpuAddress   = '0;
        cpuWriteData = '0;
        exp_ld       = '0;
        for (int i = 0; i < 64; i++) refb[i] = 8'(seed(i / 4) >> (8 * (3 - i % 4)));
        @(negedge clk);
        @(negedge clk);
        preload = 1'b0;
        reset   = 1'b0;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        check("rst.rd", 32'(m.memoryRead), 32'd0);
        check("rst.wr", 32'(m.memoryWrite), 32'd0);
        check("rst.loadData", loadData, 32'd0);
        check("rst.address", m.address, 32'd0);
        check("rst.writeData", m.writeData, 32'd0);

        run_req(1, 2'd2, 0, 32'd8, 32'hDEAD_BEEF, "st_w8");
        run_req(0, 2'd2, 0, 32'd8, 32'h0, "ld_w8");
        check("ld_w8.const", loadData, 32'hDEAD_BEEF);
        run_req(1, 2'd2, 0, 32'd8, 32'h1122_3344, "st_w8b");
        run_req(1, 2'd0, 0, 32'd9, 32'h0000_00AA, "st_b9");
        run_req(0, 2'd0, 1, 32'd9, 32'h0, "ld_sb9");
        if (SUB) begin
            check("st_b9.const", mem_w[2], 32'h11AA_3344);
            check("ld_sb9.const", loadData, 32'hFFFF_FFAA);
        end
        run_req(0, 2'd0, 0, 32'd9, 32'h0, "ld_ub9");
        run_req(0, 2'd1, 1, 32'd10, 32'h0, "ld_sh10");
        if (SUB) check("ld_sh10.const", loadData, 32'h0000_3344);
        run_req(0, 2'd2, 0, 32'd6, 32'h0, "err_w6");
        run_req(0, 2'd1, 0, 32'd5, 32'h0, "err_h5");
        run_req(0, 2'd3, 0, 32'd8, 32'h0, "err_sz3");
        run_req(0, 2'd2, 0, 32'd62, 32'h0, "err_w62");
        run_req(1, 2'd2, 0, 32'd64, 32'h1234_5678, "err_w64");
        run_req(0, 2'd2, 0, 32'd60, 32'h0, "ld_w60");

        // start held high across a whole load and into the next one
        rd0   = rd_cnt;
        dmask = '0;
        @(negedge clk);
        opWrite    = 1'b0;
        size       = 2'd2;
        cpuAddress = 32'd20;
        start      = 1'b1;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            dmask[k] = done;
        end
        start  = 1'b0;
        exp_ld = ref_word(32'd20);
        check("hold.donemask", 32'(dmask), 32'h88);
        check("hold.reads", 32'(rd_cnt - rd0), 32'd2);
        check("hold.loadData", loadData, exp_ld);
        @(negedge clk);

        // reset while a load sits in RD
        @(negedge clk);
        cpuAddress = 32'd24;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_ld = '0;
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.done", 32'(done), 32'd0);
        check("rstmid.rd", 32'(m.memoryRead), 32'd0);
        check("rstmid.loadData", loadData, 32'd0);
        run_req(0, 2'd2, 0, 32'd24, 32'h0, "after_rst");

        for (int i = 0; i < 40; i++)
            run_req(1'($urandom), 2'($urandom), 1'($urandom),
                    32'($urandom_range(0, 71)), $urandom, "rand");

        check("never_both", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
